carry_window_counter: RTL and testbench
=======================================

# carry_window_counter

Downstream consumer of the modulo-M accumulator's wrap flags. It samples the per-cycle overflow (`cop`) and underflow (`con`) indications. Over a fixed window of WIN enabled clock cycles it forms the net signed wrap count. It then presents each window's result on a valid/ready output for the measurement/control logic that follows.

## Interface
- `CNT_W`, 16: width of the signed net-count accumulator and result. Must be ≥ 2.
- `WIN`, 1000: window length in enabled clk cycles. Must be ≥ 2. The window counter width is clog2(WIN).
- `clk` input 1: clock. Rising edge active.
- `arst` input 1: reset. Asynchronous, active-high.
- `en` input 1: sampling enable. When low, the window counter and accumulator hold.
- `clr` input 1: synchronous restart of the window. Takes priority over `en`.
- `cop` input 1: accumulator overflow flag for this cycle (+1 wrap).
- `con` input 1: accumulator underflow flag for this cycle (−1 wrap).
- `res_ready` input 1: downstream accepts the result.
- `res_valid` output 1: a window result is held.
- `res_net` output CNT_W, signed: net wraps in the window.
- `res_sat` output 1: the accumulator saturated during that window.
- `res_ovr` output 1: this result overwrote an unaccepted previous result.

## Operation
- **Reset values:** `res_valid`=0, `res_net`=0, `res_sat`=0, `res_ovr`=0. Internal state is also cleared: `acc`=0, `win_cnt`=0, `sat_acc`=0.
- **Per-cycle step value `d`:**
  - `cop` & !`con` → +1
  - `con` & !`cop` → −1
  - both set or neither set → 0
- **Sampling:** on each edge with `en`=1 and `clr`=0:
  - `acc` ← sat(`acc` + `d`). Saturation limits are +(2^(CNT_W−1)−1) and −2^(CNT_W−1).
  - `sat_acc` ← `sat_acc` | (saturation clipped this cycle).
  - `win_cnt` increments.
- **Window close:** the enabled edge with `win_cnt`==WIN−1 closes the window.
  - `res_net` ← sat(`acc` + `d`), so the closing cycle's event is included.
  - `res_sat` ← `sat_acc` | (saturation clipped on this cycle).
  - `res_valid` ← 1.
  - `res_ovr` ← `res_valid` & !`res_ready`, evaluated in the same cycle.
  - `acc`, `win_cnt` and `sat_acc` ← 0. The next window starts on the following enabled edge.
- **Handshake:** the result transfers on an edge where `res_valid` & `res_ready`. `res_valid` then falls to 0, unless a window closes on that same edge, in which case it stays 1 and the new result loads with `res_ovr`=0. `res_net`, `res_sat` and `res_ovr` stay stable while `res_valid`=1 and no window closes.
- **Overrun:** if a window closes while an unaccepted result is held, the new result replaces the old one and `res_ovr`=1. The old result is lost.
- **`clr`=1:**
  - `acc`, `win_cnt` and `sat_acc` ← 0. The current cycle's `cop`/`con` are discarded.
  - The output register and handshake are unaffected.
- **`en`=0:** `cop`/`con` are ignored. `acc`, `win_cnt` and `sat_acc` hold. The output handshake keeps operating.
- **Asynchronous `arst`** at any time, including mid-window or while a result is pending: all state returns to reset values and the pending result is discarded. The first enabled edge after release is window cycle 0.

## Timing
- A window spans exactly WIN enabled rising edges. Disabled cycles stretch it without affecting the count.
- Result latency: `res_valid` is high in the cycle immediately after the closing edge.
- There is no combinational path from inputs to outputs. All outputs are registered.
- Throughput is one result per window. Accepting with `res_ready` held high never produces an overrun.
- `cop`/`con` are sampled every enabled cycle. A level held high for n enabled cycles counts n wraps.

## Test plan
1. **Reset check.** Hold `arst`=1 for 3 cycles, then release with `en`=0 → all outputs 0. No `res_valid` appears for 20 cycles.
2. **Basic window.** WIN=8, CNT_W=8, `en`=1, `res_ready`=1. Drive `cop` high in cycles 1, 3 and 7 and `con` high in cycle 4 → `res_net`=+2, `res_sat`=0, `res_ovr`=0. `res_valid` pulses for exactly 1 cycle, one cycle after the 8th enabled edge.
3. **Simultaneous flags, then underflow window.** WIN=8.
   - `cop`=`con`=1 for all 8 cycles → `res_net`=0.
   - Next window, `con`=1 for all 8 cycles → `res_net`=−8.
4. **Saturation.** CNT_W=4, WIN=20.
   - `cop`=1 for all cycles → `res_net`=+7, `res_sat`=1.
   - Next window, `con`=1 for all cycles → `res_net`=−8, `res_sat`=1.
5. **Overrun and stall.** WIN=8, `res_ready`=0 for two windows.
   - First result: `res_net`=+1.
   - Second result: `res_net`=+3, `res_ovr`=1, and `res_valid` stays high throughout.
   - Then raise `res_ready` for 1 cycle → `res_valid` falls.
6. **Enable gap, clear, reset mid-window.** WIN=8.
   - Toggle `en` low for 5 cycles mid-window → the window closes after 8 enabled edges with the correct count.
   - Assert `clr` at enabled cycle 5 with `cop`=1 → that event is dropped and the window restarts.
   - Assert `arst` at cycle 4 of a window with a pending result → `res_valid`=0 and the next result counts only post-release events.

Source files
------------

// File: rtl/carry_window_counter.sv
// carry_window_counter
//   Samples the overflow/underflow wrap flags of a modulo-M accumulator and
//   accumulates their net signed count over windows of WIN enabled cycles.
//   Each closed window is presented on a valid/ready result port together
//   with a saturation flag and an overrun flag.
//
// Parameters
//   CNT_W      width of the signed net-count accumulator and result (>= 2)
//   WIN        window length in enabled clk cycles (>= 2)
//
// Ports
//   clk        clock, rising edge active
//   arst       asynchronous reset, active high
//   en         sampling enable; window counter and accumulator hold when low
//   clr        synchronous window restart, priority over en
//   cop        overflow flag for this cycle (+1)
//   con        underflow flag for this cycle (-1)
//   res_ready  downstream accepts the held result
//   res_valid  a window result is held
//   res_net    net signed wrap count of the window
//   res_sat    accumulator saturated during that window
//   res_ovr    this result replaced an unaccepted previous result
module carry_window_counter #(
    parameter int CNT_W = 16,
    parameter int WIN   = 1000
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    cop,
    input  logic                    con,
    input  logic                    res_ready,
    output logic                    res_valid,
    output logic signed [CNT_W-1:0] res_net,
    output logic                    res_sat,
    output logic                    res_ovr
);

    localparam int              WCW      = $clog2(WIN);
    localparam logic [WCW-1:0]  WIN_LAST = WCW'(WIN - 1);
    localparam logic [CNT_W-1:0] SAT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] SAT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    logic [CNT_W-1:0]        acc_q, acc_d;
    logic [WCW-1:0]          win_cnt_q, win_cnt_d;
    logic                    sat_acc_q, sat_acc_d;
    logic                    res_valid_q, res_valid_d;
    logic signed [CNT_W-1:0] res_net_q, res_net_d;
    logic                    res_sat_q, res_sat_d;
    logic                    res_ovr_q, res_ovr_d;

    logic [CNT_W:0]   step_ext;
    logic [CNT_W:0]   sum_ext;
    logic             clip;
    logic [CNT_W-1:0] acc_next;
    logic             close;

    // Saturating add of the per-cycle step. The sum is formed one bit wider;
    // since the step is at most +/-1, a clip shows up as the two top bits of
    // the widened sum disagreeing, and the top bit tells which rail to use.
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        step_ext = '0;
        if (cop && !con) begin
            step_ext = (CNT_W+1)'(1);
        end else if (con && !cop) begin
            step_ext = '1;
        end
        sum_ext = {acc_q[CNT_W-1], acc_q} + step_ext;
        clip    = sum_ext[CNT_W] ^ sum_ext[CNT_W-1];
        if (!clip) begin
            acc_next = sum_ext[CNT_W-1:0];
        end else if (sum_ext[CNT_W]) begin
            acc_next = SAT_MIN;
        end else begin
            acc_next = SAT_MAX;
        end
    end

    assign close = en && !clr && (win_cnt_q == WIN_LAST);

    // Window accumulation state.
    always_comb begin
        acc_d     = acc_q;
        win_cnt_d = win_cnt_q;
        sat_acc_d = sat_acc_q;
        if (clr || close) begin
            // The closing cycle's step goes into the result, not the next window.
            acc_d     = '0;
            win_cnt_d = '0;
            sat_acc_d = 1'b0;
        end else if (en) begin
            acc_d     = acc_next;
            win_cnt_d = win_cnt_q + WCW'(1);
            sat_acc_d = sat_acc_q | clip;
        end
    end

    // Result register and handshake. A close on the accepting edge reloads
    // the register, so the later assignment deliberately overrides the drop.
    always_comb begin
        res_valid_d = res_valid_q;
        res_net_d   = res_net_q;
        res_sat_d   = res_sat_q;
        res_ovr_d   = res_ovr_q;
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
        if (close) begin
            res_valid_d = 1'b1;
            res_net_d   = acc_next;
            res_sat_d   = sat_acc_q | clip;
            res_ovr_d   = res_valid_q && !res_ready;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            acc_q       <= '0;
            win_cnt_q   <= '0;
            sat_acc_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_net_q   <= '0;
            res_sat_q   <= 1'b0;
            res_ovr_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            win_cnt_q   <= win_cnt_d;
            sat_acc_q   <= sat_acc_d;
            res_valid_q <= res_valid_d;
            res_net_q   <= res_net_d;
            res_sat_q   <= res_sat_d;
            res_ovr_q   <= res_ovr_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_net   = res_net_q;
    assign res_sat   = res_sat_q;
    assign res_ovr   = res_ovr_q;

endmodule

// File: tb/tb_carry_window_counter.sv
// Bench for carry_window_counter. Two instances share all inputs:
//   dut_a: CNT_W=8, WIN=8   (basic, flags, overrun, enable/clear/reset cases)
//   dut_b: CNT_W=4, WIN=20  (saturation case)
// A reference model records every enabled step of the current window and
// folds the window with saturating arithmetic when it reaches WIN steps.
module tb_carry_window_counter;

    logic clk = 1'b0;
    logic arst = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic cop = 1'b0;
    logic con = 1'b0;
    logic res_ready = 1'b0;

    logic              a_valid, a_sat, a_ovr;
    logic signed [7:0] a_net;
    logic              b_valid, b_sat, b_ovr;
    logic signed [3:0] b_net;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    carry_window_counter #(.CNT_W(8), .WIN(8)) dut_a (
        .clk(clk), .arst(arst), .en(en), .clr(clr), .cop(cop), .con(con),
        .res_ready(res_ready), .res_valid(a_valid), .res_net(a_net),
        .res_sat(a_sat), .res_ovr(a_ovr)
    );

    carry_window_counter #(.CNT_W(4), .WIN(20)) dut_b (
        .clk(clk), .arst(arst), .en(en), .clr(clr), .cop(cop), .con(con),
        .res_ready(res_ready), .res_valid(b_valid), .res_net(b_net),
        .res_sat(b_sat), .res_ovr(b_ovr)
    );

    // ---------------- reference model ----------------
    int  wins [2] = '{8, 20};
    int  cws  [2] = '{8, 4};
    int  steps[2][0:31];
    int  nst  [2];
    bit  m_valid[2];
    int  m_net  [2];
    bit  m_sat  [2];
    bit  m_ovr  [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            nst[k] = 0; m_valid[k] = 0; m_net[k] = 0; m_sat[k] = 0; m_ovr[k] = 0;
        end
    endtask

    // Replay the window's steps in order, clamping after each one.
    task automatic fold(input int k, output int net, output bit sat);
        int lo, hi;
        lo  = -(1 << (cws[k] - 1));
        hi  = (1 << (cws[k] - 1)) - 1;
        net = 0;
        sat = 0;
        for (int i = 0; i < nst[k]; i++) begin
            net = net + steps[k][i];
            if (net > hi) begin net = hi; sat = 1; end
            if (net < lo) begin net = lo; sat = 1; end
        end
    endtask

    task automatic model_edge();
        int d, net;
        bit pre, sat;
        if (arst) begin
            model_reset();
            return;
        end
        d = (cop && !con) ? 1 : ((con && !cop) ? -1 : 0);
        for (int k = 0; k < 2; k++) begin
            pre = m_valid[k];
            if (pre && res_ready) m_valid[k] = 0;
            if (clr) begin
                nst[k] = 0;
            end else if (en) begin
                steps[k][nst[k]] = d;
                nst[k]++;
                if (nst[k] == wins[k]) begin
                    fold(k, net, sat);
                    m_net[k]   = net;
                    m_sat[k]   = sat;
                    m_ovr[k]   = pre && !res_ready;
                    m_valid[k] = 1;
                    nst[k]     = 0;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("a_valid", int'(a_valid), int'(m_valid[0]));
        check("a_ovr",   int'(a_ovr),   int'(m_ovr[0]));
        check("b_valid", int'(b_valid), int'(m_valid[1]));
        check("b_ovr",   int'(b_ovr),   int'(m_ovr[1]));
        check("a_net",   int'(a_net),   m_net[0]);
        check("a_sat",   int'(a_sat),   int'(m_sat[0]));
        check("b_net",   int'(b_net),   m_net[1]);
        check("b_sat",   int'(b_sat),   int'(m_sat[1]));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit e, input bit c, input bit p, input bit n);
        en = e; clr = c; cop = p; con = n;
    endtask

    initial begin
        model_reset();

        // 1. Reset, then 20 idle cycles with en=0.
        arst = 1'b1;
        repeat (3) step();
        arst = 1'b0;
        check("rst_a_valid", int'(a_valid), 0);
        check("rst_a_net",   int'(a_net),   0);
        check("rst_a_sat",   int'(a_sat),   0);
        check("rst_a_ovr",   int'(a_ovr),   0);
        check("rst_b_valid", int'(b_valid), 0);
        repeat (20) begin
            step();
            check("idle_a_valid", int'(a_valid), 0);
        end

        // 2. Basic window: cop in cycles 1,3,7, con in cycle 4.
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, (i == 1 || i == 3 || i == 7), (i == 4));
            step();
            if (i < 7) check("basic_no_early_valid", int'(a_valid), 0);
        end
        check("basic_valid", int'(a_valid), 1);
        check("basic_net",   int'(a_net),   2);
        check("basic_sat",   int'(a_sat),   0);
        check("basic_ovr",   int'(a_ovr),   0);

        // 3. Simultaneous flags, then an all-underflow window.
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 1, 1);
            step();
            if (i == 0) check("basic_pulse_one_cycle", int'(a_valid), 0);
        end
        check("both_valid", int'(a_valid), 1);
        check("both_net",   int'(a_net),   0);
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 1);
            step();
        end
        check("under_valid", int'(a_valid), 1);
        check("under_net",   int'(a_net),   -8);
        check("under_sat",   int'(a_sat),   0);

        // 4. Saturation on the narrow instance, windows aligned by clr.
        drive(1, 1, 0, 0);
        step();
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 1, 0);
            step();
        end
        check("satp_valid", int'(b_valid), 1);
        check("satp_net",   int'(b_net),   7);
        check("satp_sat",   int'(b_sat),   1);
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 1);
            step();
        end
        check("satn_valid", int'(b_valid), 1);
        check("satn_net",   int'(b_net),   -8);
        check("satn_sat",   int'(b_sat),   1);

        // 5. Overrun with res_ready low for two windows.
        drive(1, 1, 0, 0);
        step();
        res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, (i == 2), 0);
            step();
        end
        check("ovr1_valid", int'(a_valid), 1);
        check("ovr1_net",   int'(a_net),   1);
        check("ovr1_ovr",   int'(a_ovr),   0);
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, (i == 0 || i == 1 || i == 5), 0);
            step();
            check("ovr_hold_valid", int'(a_valid), 1);
        end
        check("ovr2_net", int'(a_net), 3);
        check("ovr2_ovr", int'(a_ovr), 1);
        drive(0, 0, 0, 0);
        res_ready = 1'b1;
        step();
        check("ovr_drain_valid", int'(a_valid), 0);

        // 6a. Enable gap of 5 cycles mid-window; flags during the gap ignored.
        drive(1, 1, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin drive(1, 0, 1, 0); step(); end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 1);
            step();
            check("gap_no_valid", int'(a_valid), 0);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, (i == 1), (i == 3));
            step();
        end
        check("gap_valid", int'(a_valid), 1);
        check("gap_net",   int'(a_net),   3);

        // 6b. clr at enabled cycle 5 with cop=1 restarts the window.
        for (int i = 0; i < 5; i++) begin drive(1, 0, 1, 0); step(); end
        drive(1, 1, 1, 0);
        step();
        check("clr_no_valid", int'(a_valid), 0);
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, (i == 2 || i == 6), 0);
            step();
        end
        check("clr_valid", int'(a_valid), 1);
        check("clr_net",   int'(a_net),   2);

        // 6c. Reset mid-window while a result is pending.
        drive(0, 0, 0, 0);
        step();
        res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin drive(1, 0, (i == 0), 0); step(); end
        check("pend_valid", int'(a_valid), 1);
        for (int i = 0; i < 4; i++) begin drive(1, 0, 1, 0); step(); end
        arst = 1'b1;
        #1;
        model_reset();
        check("arst_a_valid", int'(a_valid), 0);
        check("arst_a_net",   int'(a_net),   0);
        compare_all();
        repeat (2) step();
        arst = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, (i == 1 || i == 6));
            step();
        end
        check("post_rst_valid", int'(a_valid), 1);
        check("post_rst_net",   int'(a_net),   -2);
        check("post_rst_ovr",   int'(a_ovr),   0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        // Long one-sided bursts to exercise saturation under random handshake.
        for (int i = 0; i < 200; i++) begin
            drive(1, 0, (i < 100), (i >= 100));
            res_ready = $urandom_range(0, 1) == 1;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
